// File: rtl/parity_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | parity_pkg : shared state encoding, parity-mode constants, saturating inc   |
// | Revision   : 1.0                                                            |
// +----------------------------------------------------------------------------+
package parity_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    RESULT = 2'd2
  } state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Holds at all-ones of a w-bit field (w <= 32).
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] max_v;
    max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (v >= max_v) ? v : v + 32'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/parity_stream_sat_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sat_counter : W-bit saturating up-counter, synchronous clear beats inc      |
// | Revision    : 1.0                                                           |
// +----------------------------------------------------------------------------+
module sat_counter
  import parity_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = W'(sat_inc(32'(cnt_q), W));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule
`default_nettype wire

// File: rtl/parity_stream.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | parity_stream : framed streaming parity generator/checker with error count  |
// | Revision      : 1.0                                                         |
// +----------------------------------------------------------------------------+
module parity_stream
  import parity_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 8,
  parameter int ERR_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic              in_par,
  input  logic              cfg_odd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_par,
  output logic              out_err,
  output logic [CNT_W-1:0]  out_len,
  output logic [ERR_W-1:0]  err_cnt,
  input  logic              clr_err
);

  state_t             state_d, state_q;
  logic               acc_d, acc_q;
  logic               mode_d, mode_q;
  logic               out_par_d, out_par_q;
  logic               out_err_d, out_err_q;
  logic [CNT_W-1:0]   out_len_d, out_len_q;
  logic [CNT_W-1:0]   len_cnt;
  logic               in_xfer, out_xfer, word_par, err_inc;

  // Gated by rst so the port reads 0 throughout reset, not just after it.
  assign in_ready  = ~rst & (state_q != RESULT);
  assign out_valid = (state_q == RESULT);
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;
  assign word_par  = ^in_data;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mode_d    = mode_q;
    out_par_d = out_par_q;
    out_err_d = out_err_q;
    out_len_d = out_len_q;
    err_inc   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (in_xfer) begin
          mode_d  = cfg_odd;
          acc_d   = word_par;
          state_d = in_last ? RESULT : ACCUM;
        end
      end
      ACCUM: begin
        if (in_xfer) begin
          acc_d = acc_q ^ word_par;
          if (in_last) state_d = RESULT;
        end
      end
      RESULT: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // len_cnt is 0 at the first word, so one saturating step gives the final length.
    if (in_xfer && in_last) begin
      out_par_d = acc_d ^ mode_d;
      out_err_d = out_par_d ^ in_par;
      out_len_d = CNT_W'(sat_inc(32'(len_cnt), CNT_W));
      err_inc   = out_err_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      acc_q     <= 1'b0;
      mode_q    <= PAR_EVEN;
      out_par_q <= 1'b0;
      out_err_q <= 1'b0;
      out_len_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mode_q    <= mode_d;
      out_par_q <= out_par_d;
      out_err_q <= out_err_d;
      out_len_q <= out_len_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_len_cnt (
    .clk (clk),
    .rst (rst),
    .inc (in_xfer),
    .clr (out_xfer),
    .cnt (len_cnt)
  );

  sat_counter #(.W(ERR_W)) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .inc (err_inc),
    .clr (clr_err),
    .cnt (err_cnt)
  );

  assign out_par = out_par_q;
  assign out_err = out_err_q;
  assign out_len = out_len_q;

endmodule
`default_nettype wire

// File: tb/tb_parity_stream.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_parity_stream : scoreboard bench for parity_stream (narrow counters)     |
// | Revision         : 1.0                                                      |
// +----------------------------------------------------------------------------+
module tb_parity_stream;
  import parity_pkg::*;

  localparam int DATA_W  = 4;
  localparam int CNT_W   = 2;
  localparam int ERR_W   = 2;
  localparam int LEN_MAX = 3;
  localparam int ERR_MAX = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_last = 1'b0;
  logic              in_par = 1'b0;
  logic              cfg_odd = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic              out_par;
  logic              out_err;
  logic [CNT_W-1:0]  out_len;
  logic [ERR_W-1:0]  err_cnt;
  logic              clr_err = 1'b0;

  typedef struct packed {
    logic             par;
    logic             err;
    logic [CNT_W-1:0] len;
  } exp_t;

  exp_t              sb[$];
  logic [DATA_W-1:0] frame_words[$];
  int                errors = 0;
  int                checks = 0;
  int                exp_err_cnt = 0;

  always #5 clk = ~clk;

  parity_stream #(.DATA_W(DATA_W), .CNT_W(CNT_W), .ERR_W(ERR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_par    (in_par),
    .cfg_odd   (cfg_odd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_par   (out_par),
    .out_err   (out_err),
    .out_len   (out_len),
    .err_cnt   (err_cnt),
    .clr_err   (clr_err)
  );

  task automatic send_word(input logic [DATA_W-1:0] d, input logic last, input logic par,
                           input logic odd, input logic clr);
    int waitc;
    waitc = 0;
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_last = last; in_par = par; cfg_odd = odd; clr_err = clr;
    while (!in_ready && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL accept_timeout: in_ready=%b required=1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_last = 1'b0; clr_err = 1'b0;
  endtask

  // Drives frame_words; non-last words carry inverted in_par and optionally toggled cfg_odd.
  task automatic send_frame(input logic odd, input logic par, input logic clr_at_end,
                            input logic toggle_cfg);
    logic acc;
    exp_t e;
    int   n;
    acc = 1'b0;
    n = frame_words.size();
    for (int i = 0; i < n; i++) begin
      acc ^= ^frame_words[i];
      send_word(frame_words[i], (i == n-1), (i == n-1) ? par : ~par,
                (toggle_cfg && i > 0) ? ~odd : odd, clr_at_end && (i == n-1));
    end
    e.par = acc ^ odd;
    e.err = e.par ^ par;
    e.len = CNT_W'((n > LEN_MAX) ? LEN_MAX : n);
    sb.push_back(e);
    if (clr_at_end) exp_err_cnt = 0;
    else if (e.err && exp_err_cnt < ERR_MAX) exp_err_cnt++;
  endtask

  task automatic collect(input string name);
    exp_t e;
    int   waitc;
    waitc = 0;
    @(negedge clk);
    while (!out_valid && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    checks++;
    if (!out_valid) begin
      errors++;
      $display("FAIL %s_timeout: out_valid=%b required=1", name, out_valid);
    end else if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s_unexpected: result with empty scoreboard", name);
    end else begin
      e = sb.pop_front();
      if ({out_par, out_err, out_len} !== {e.par, e.err, e.len}) begin
        errors++;
        $display("FAIL %s_result: par/err/len=%b/%b/%0d required %b/%b/%0d",
                 name, out_par, out_err, out_len, e.par, e.err, e.len);
      end
      checks++;
      if (err_cnt !== ERR_W'(exp_err_cnt)) begin
        errors++;
        $display("FAIL %s_err_cnt: err_cnt=%0d required %0d", name, err_cnt, exp_err_cnt);
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if ({in_ready, out_valid, out_par, out_err, out_len, err_cnt} !== '0) begin
      errors++;
      $display("FAIL %s: rdy/vld/par/err/len/cnt=%b/%b/%b/%b/%0d/%0d required all 0",
               name, in_ready, out_valid, out_par, out_err, out_len, err_cnt);
    end
  endtask

  task automatic test_reset();
    #2;
    check_all_zero("reset_initial");
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    frame_words = '{4'b0000};
    send_frame(PAR_EVEN, 1'b1, 1'b0, 1'b0);
    collect("pre_reset_err");
    send_word(4'b0111, 1'b0, 1'b0, PAR_ODD, 1'b0);
    send_word(4'b0001, 1'b0, 1'b0, PAR_ODD, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_all_zero("reset_mid_frame");
    @(negedge clk);
    rst = 1'b0;
    exp_err_cnt = 0;
    frame_words = '{4'b0001};
    send_frame(PAR_EVEN, 1'b1, 1'b0, 1'b0);
    collect("after_reset");
  endtask

  task automatic test_even_frame();
    frame_words = '{4'b0011, 4'b0101, 4'b1000};
    send_frame(PAR_EVEN, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL latency: out_valid=%b required 1 one cycle after last accept", out_valid);
    end
    collect("even_frame");
  endtask

  task automatic test_odd_toggle();
    frame_words = '{4'b0011, 4'b0101, 4'b1000};
    send_frame(PAR_ODD, 1'b1, 1'b0, 1'b1);
    collect("odd_toggle");
  endtask

  task automatic test_backpressure();
    exp_t e;
    frame_words = '{4'b0001, 4'b0010, 4'b0100};
    send_frame(PAR_EVEN, 1'b1, 1'b0, 1'b0);
    e = sb[0];
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = 4'b1111; in_last = 1'b1;
      checks++;
      if ({out_valid, in_ready, out_par, out_len} !== {1'b1, 1'b0, e.par, e.len}) begin
        errors++;
        $display("FAIL backpressure_hold%0d: vld/rdy/par/len=%b/%b/%b/%0d required 1/0/%b/%0d",
                 i, out_valid, in_ready, out_par, out_len, e.par, e.len);
      end
    end
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    collect("backpressure");
    @(negedge clk);
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL backpressure_idle: vld/rdy=%b/%b required 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_saturation();
    frame_words = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
    send_frame(PAR_EVEN, 1'b0, 1'b0, 1'b0);
    collect("len_sat");
    frame_words = '{4'b0000};
    for (int i = 0; i < 5; i++) begin
      send_frame(PAR_EVEN, 1'b1, 1'b0, 1'b0);
      collect("err_sat");
    end
  endtask

  task automatic test_clear_priority();
    frame_words = '{4'b0000};
    send_frame(PAR_EVEN, 1'b1, 1'b1, 1'b0);
    collect("clr_wins");
    send_frame(PAR_EVEN, 1'b1, 1'b0, 1'b0);
    collect("after_clr");
  endtask

  initial begin
    test_reset();
    test_reset_mid_frame();
    test_even_frame();
    test_odd_toggle();
    test_backpressure();
    test_saturation();
    test_clear_priority();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d results outstanding, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/parity_stream.md
Name: parity_stream

Overview:
Sequential, parametrised successor to the 4-input combinational parity block. It accepts a stream of DATA_W-bit words over a valid/ready handshake, grouped into frames delimited by in_last, and accumulates parity across each frame. At frame end it presents the generated parity bit, a mismatch flag against the parity received with the last word, and the frame length. It also keeps a saturating count of parity errors, and sits between a word source and a downstream checker or status register.

Parameters:
DATA_W, 4, width of each input word (>=1)
CNT_W, 8, width of frame-length counter and out_len
ERR_W, 16, width of saturating error counter

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  input word valid
in_ready  output  1  block can accept a word
in_data  input  DATA_W  input word
in_last  input  1  word is last of frame (qualified by in_valid)
in_par  input  1  received parity bit to check, sampled with the last word only
cfg_odd  input  1  0 = even parity, 1 = odd parity; sampled on first word of frame
out_valid  output  1  frame result valid
out_ready  input  1  downstream accepts result
out_par  output  1  generated parity for the frame
out_err  output  1  out_par != in_par sampled at last word
out_len  output  CNT_W  words in frame, saturating
err_cnt  output  ERR_W  count of frames with out_err=1, saturating
clr_err  input  1  synchronous clear of err_cnt

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high. While rst=1, all outputs are 0: in_ready=0, out_valid=0, out_par=0, out_err=0, out_len=0, err_cnt=0. The FSM is in IDLE and the accumulator, counter and latched mode are all 0.
- Transfer rule: a word transfers when in_valid & in_ready. A result transfers when out_valid & out_ready.
- FSM states: IDLE, ACCUM, RESULT.
  - IDLE: in_ready=1. On transfer, latch cfg_odd into mode, set acc = ^in_data and len = 1. Go to ACCUM, or to RESULT if in_last.
  - ACCUM: in_ready=1. On transfer, acc ^= ^in_data and len increments, saturating at 2^CNT_W-1. If in_last, go to RESULT. With no transfer, hold.
  - RESULT: in_ready=0 and out_valid=1. Outputs are stable until the result transfers; on transfer go to IDLE. There is no back-to-back overlap, so one idle-accept cycle follows each result.
- Parity rule: out_par = (XOR of every bit of every word in the frame) ^ mode. In even mode the total count of ones including out_par is even; in odd mode it is odd.
- out_err = out_par ^ in_par, with in_par sampled on the last-word transfer.
- Latency: out_valid rises on the clock edge that accepts the last word, so it is visible in the next cycle. A single-word frame accepted in cycle N gives out_valid=1 in cycle N+1.
- cfg_odd changes mid-frame are ignored. in_par is ignored on non-last words.
- Error counter: err_cnt increments by 1 on the cycle the FSM enters RESULT with out_err=1, saturating at 2^ERR_W-1.
  - clr_err sets err_cnt to 0 on the next edge.
  - If clr_err and an increment occur in the same cycle, clear wins (result 0).
- Reset mid-frame discards the partial frame and any pending result. err_cnt also returns to 0.
- out_par, out_err and out_len are registered and hold their last value after the result transfers. They are meaningful only while out_valid=1.

Decomposition:
- Shared package parity_pkg:
  - state enum (IDLE=2'd0, ACCUM=2'd1, RESULT=2'd2)
  - PAR_EVEN=1'b0 and PAR_ODD=1'b1 constants
  - a function for saturating increment
- One natural sub-module, sat_counter (parameter W; ports inc, clr, cnt), used for both len and err_cnt.
- Word-parity reduction stays inline in parity_stream.

Test Plan:
1. Reset applied mid-frame (2 of 3 words sent) -> all outputs 0. The next frame {4'b0001, last} in even mode gives out_par=1 and out_len=1, with no stale accumulation.
2. Frame 4'b0011, 4'b0101, 4'b1000 (last), even mode, in_par=1 -> out_par=1, out_err=0, out_len=3. out_valid is seen the cycle after the last accept.
3. Same frame with cfg_odd=1 at the first word, then toggled mid-frame, in_par=1 -> out_par=0, out_err=1, err_cnt=1.
4. Backpressure: hold out_ready=0 for 5 cycles -> out_valid, out_par and out_len are stable, in_ready=0, and words offered are not accepted. out_ready=1 then leads to IDLE the next cycle.
5. Length saturation, CNT_W=2: 6-word frame -> out_len=3. Error saturation, ERR_W=2: 5 erroneous frames -> err_cnt=3.
6. clr_err asserted in the same cycle an erroneous frame ends -> err_cnt=0. The next erroneous frame gives err_cnt=1.
